context_update: RTL and testbench
=================================

Name: context_update

Overview:
- Stage directly downstream of the context-quantization stage in the LOCO-I pipeline.
- Consumes the context index Q, the sign flag, and the aligned Ix/Px.
- Holds the per-context statistics A/B/C/N and applies bias correction to Px. Computes the modulo-reduced, mapped prediction error and the Golomb parameter k.
- Writes the updated statistics back, feeding the Golomb coder.

Parameters:
- CTX_NUM, 365, number of contexts; valid Q is 0..CTX_NUM-1.
- RESET_N, 64, N threshold at which A, B and N are halved.
- A_INIT, 4, initial A value for RANGE=256.
- A_W, 16, width of the A accumulator.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- en  in  1  input valid, one sample per cycle
- Q  in  9  context index
- sign  in  1  context sign; 1 = negative context
- Ix  in  9  actual pixel, 0..255
- Px  in  9  MED prediction, 0..255
- MErrval  out  9  mapped error, 0..255
- k  out  4  Golomb parameter
- en_out  out  1  output valid
- init_busy  out  1  high while the context table is being initialised

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: MErrval=0, k=0, en_out=0, all pipeline registers 0. FSM enters INIT with init_busy=1.
- FSM INIT:
  - A counter writes A=A_INIT, B=0, C=0, N=1 into entries 0..CTX_NUM-1, one entry per cycle.
  - After entry CTX_NUM-1 is written, go to RUN. init_busy falls on the cycle RUN is entered (365 cycles after reset release).
  - en is ignored in INIT; the controller holds en low. en_out stays 0.
- FSM RUN:
  - Fully pipelined. One sample per cycle, no stall.
  - en sampled at edge t gives en_out=1 during the cycle after edge t+1 (2-cycle latency, matching the upstream stage).
- Stage 1: register Q, sign, Ix, Px. Synchronous read of the context table at Q.
- Stage 2 computes combinationally, then registers the outputs and writes the context back at the same edge. Steps in order:
  - Px' = Px+C if sign=0, else Px-C. Clamp Px' to 0..255.
  - Errval = Ix-Px'. Negate Errval if sign=1.
  - Modulo reduction: if Errval < -128, add 256; if Errval >= 128, subtract 256.
  - k = smallest k in 0..15 with (N<<k) >= A. Saturate k at 15.
  - Error mapping special case: if k==0 and 2B <= -N, then Errval >= 0 gives 2*Errval+1, else -2*(Errval+1).
  - Error mapping default: Errval >= 0 gives 2*Errval, else -2*Errval-1.
- Statistics update, in order:
  - B += Errval; A += |Errval|.
  - If N == RESET_N: A >>= 1, B >>= 1 (arithmetic), N >>= 1.
  - N += 1.
  - If B <= -N: B += N; C -= 1 if C > -128; then if B <= -N, set B = -N+1.
  - Else if B > 0: B -= N; C += 1 if C < 127; then if B > 0, set B = 0.
- Storage widths: A unsigned A_W bits; B signed 12 bits; C signed 8 bits; N unsigned 7 bits (range 1..64).
- Read-after-write hazard: if the stage-1 Q equals the stage-2 Q (back-to-back same context), stage 2 uses the values just written, not the stale RAM read. Non-adjacent repeats need no bypass.
- Outside en_out: when en_out=0, MErrval and k are driven to 0.
- Out-of-range Q (Q >= CTX_NUM) with en=1: sample dropped. No en_out, no table write.
- Reset mid-operation: in-flight samples are discarded and outputs clear immediately. The table is re-initialised: INIT runs again for 365 cycles after release.

Test Plan:
- Reset release with en held low: init_busy=1 for exactly 365 cycles, then 0. en_out stays 0 throughout.
- Fresh ctx Q=5, sign=0, Px=100, Ix=103 -> two cycles later en_out=1, MErrval=6, k=2. ctx5 becomes A=7, B=0, C=1, N=2.
- Next cycle, back to back, Q=5, Px=100, Ix=100:
  - Required: bypass gives Px'=101 and Errval=-1.
  - Outputs: MErrval=1, k=2.
  - ctx5 becomes A=8, B=-1, C=1, N=3.
- Fresh Q=7, sign=1, Px=50, Ix=40 -> Errval=+10, MErrval=20, k=2.
- Modulo wrap: fresh Q=9, Px=0, Ix=255 -> Errval=-1, MErrval=1, k=2.
- Halving: Q=11 driven 64 times with Ix=Px=128 -> after the 64th sample ctx11 is A=2, N=33, B=0, C=0.
- Reset low mid-stream: en_out/MErrval/k go 0 asynchronously; init_busy=1 again for 365 cycles. ctx5 then reads the initial values (MErrval=6, k=2 for the Px=100, Ix=103 sample).

Source files
------------

// File: rtl/context_update.sv
// -----------------------------------------------------------------------------
// context_update
//
// Context statistics stage of a LOCO-I (JPEG-LS) style encoder. It sits right
// after context quantization. It keeps the per-context A/B/C/N statistics,
// applies the bias correction C to the MED prediction, and produces the
// modulo-reduced, mapped prediction error and the Golomb parameter k. The
// updated statistics are written back in the same cycle as the outputs.
//
// After reset the context table is filled with its initial values, one entry
// per cycle (INIT). Samples are accepted only after that (RUN). The pipeline
// takes one sample per cycle with two cycles of latency and never stalls.
//
// Ports
//   clk        clock
//   reset      asynchronous active-low reset
//   en         input sample valid
//   Q          context index, valid range 0..CTX_NUM-1
//   sign       context sign, 1 = negative context
//   Ix         actual pixel value, 0..255
//   Px         MED prediction, 0..255
//   MErrval    mapped prediction error, 0..255 (0 when en_out is low)
//   k          Golomb parameter (0 when en_out is low)
//   en_out     output valid
//   init_busy  high while the context table is being initialised
// -----------------------------------------------------------------------------
module context_update #(
   parameter int CTX_NUM = 365,
   parameter int RESET_N = 64,
   parameter int A_INIT  = 4,
   parameter int A_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [8:0] Q,
   input  logic       sign,
   input  logic [8:0] Ix,
   input  logic [8:0] Px,
   output logic [8:0] MErrval,
   output logic [3:0] k,
   output logic       en_out,
   output logic       init_busy
);

   // One context table entry.
   typedef struct packed {
      logic        [A_W-1:0] a;   // accumulated |Errval|
      logic signed [11:0]    b;   // accumulated Errval (bias)
      logic signed [7:0]     c;   // bias correction
      logic        [6:0]     n;   // occurrence count, 1..RESET_N
   } ctx_t;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   localparam logic [8:0]        CTX_NUM9 = 9'(CTX_NUM);
   localparam logic [8:0]        CTX_LAST = 9'(CTX_NUM - 1);
   localparam logic [6:0]        RESET_N7 = 7'(RESET_N);
   localparam logic signed [7:0] C_MIN    = 8'sh80;
   localparam logic signed [7:0] C_MAX    = 8'sh7F;
   localparam ctx_t              CTX_INIT = '{a: A_W'(A_INIT), b: 12'sd0, c: 8'sd0, n: 7'd1};

   // ---------------------------------------------------------------------------
   // Controller: walks the table once after reset, then stays in RUN.
   // ---------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;

   // NOTE: sequential state is assigned with <= only, so every flop samples
   // the values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_busy = 1'b0;
      case (state_q)
         S_INIT: begin
            init_busy = 1'b1;
            cnt_d     = cnt_q + 9'd1;
            if (cnt_q == CTX_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_INIT;
      endcase
   end

   // Samples are accepted only in RUN and only with a context index in range;
   // anything else never enters the pipeline and never touches the table.
   logic accept;
   assign accept = en && (state_q == S_RUN) && (Q < CTX_NUM9);

   // ---------------------------------------------------------------------------
   // Context table and its single write port.
   // ---------------------------------------------------------------------------
   ctx_t       ctx_mem [CTX_NUM];
   logic       wr_en;
   logic [8:0] wr_addr;
   ctx_t       wr_data;
   ctx_t       ctx_new;

   logic       v1_q;
   logic [8:0] q1_q;

   // INIT and the stage-2 write-back never overlap: reset empties the pipeline
   // and nothing is accepted until INIT has finished.
   always_comb begin
      wr_en   = v1_q;
      wr_addr = q1_q;
      wr_data = ctx_new;
      if (state_q == S_INIT) begin
         wr_en   = 1'b1;
         wr_addr = cnt_q;
         wr_data = CTX_INIT;
      end
   end

   // NOTE: the table has no reset; it is a RAM, and its contents are
   // established by the INIT walk that follows every reset instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ctx_mem[wr_addr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: capture the sample and read the table.
   // ---------------------------------------------------------------------------
   logic       s1_q;
   logic [8:0] ix1_q, px1_q;
   ctx_t       rd_q;
   ctx_t       wb_q;
   logic       fwd_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q  <= 1'b0;
         q1_q  <= '0;
         s1_q  <= 1'b0;
         ix1_q <= '0;
         px1_q <= '0;
         rd_q  <= '0;
         fwd_q <= 1'b0;
      end else begin
         v1_q  <= accept;
         q1_q  <= Q;
         s1_q  <= sign;
         ix1_q <= Ix;
         px1_q <= Px;
         if (Q < CTX_NUM9) begin
            rd_q <= ctx_mem[Q];
         end
         // The read above happens at the same edge as stage 2 writes the
         // same context, so it returns the stale entry; flag the next cycle
         // to take the freshly written copy instead.
         fwd_q <= v1_q && (Q == q1_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: bias correction, error mapping, k and statistics update.
   // ---------------------------------------------------------------------------
   ctx_t               ctx_cur;
   logic        [A_W-1:0] a_cur;
   logic signed [11:0]    b_cur;
   logic signed [7:0]     c_cur;
   logic        [6:0]     n_cur;
   logic signed [11:0]    c_ext, px_adj, px_clip, err_raw, err_sgn, err, abs_err;
   logic        [A_W+6:0] n_ext, a_ext;
   logic        [3:0]     k_d;
   logic                  k_found;
   logic                  special;
   logic        [8:0]     two_e, merr_d;
   logic        [A_W-1:0] a_t;
   logic signed [13:0]    b_t, n_pos, n_neg;
   logic signed [7:0]     c_t;
   logic        [7:0]     n_t;

   always_comb begin
      ctx_cur = fwd_q ? wb_q : rd_q;
      a_cur   = ctx_cur.a;
      b_cur   = ctx_cur.b;
      c_cur   = ctx_cur.c;
      n_cur   = ctx_cur.n;

      // Bias-corrected prediction, clamped to the pixel range.
      c_ext  = $signed({{4{c_cur[7]}}, c_cur});
      px_adj = $signed({3'b000, px1_q}) + (s1_q ? -c_ext : c_ext);
      if (px_adj < 12'sd0) begin
         px_clip = 12'sd0;
      end else if (px_adj > 12'sd255) begin
         px_clip = 12'sd255;
      end else begin
         px_clip = px_adj;
      end

      // Prediction error, sign-folded and reduced into -128..127.
      err_raw = $signed({3'b000, ix1_q}) - px_clip;
      err_sgn = s1_q ? -err_raw : err_raw;
      err     = err_sgn;
      if (err_sgn < -12'sd128) begin
         err = err_sgn + 12'sd256;
      end else if (err_sgn > 12'sd127) begin
         err = err_sgn - 12'sd256;
      end
      abs_err = err[11] ? -err : err;

      // Golomb parameter: first k where N<<k reaches A, capped at 15.
      n_ext   = (A_W + 7)'(n_cur);
      a_ext   = (A_W + 7)'(a_cur);
      k_d     = 4'd15;
      k_found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!k_found && ((n_ext << i) >= a_ext)) begin
            k_d     = 4'(i);
            k_found = 1'b1;
         end
      end

      // Error mapping. Errval is within -128..127, so the mapped value fits in
      // eight bits and 9-bit wrap-around arithmetic gives exact results:
      // ~(2e) is -2e-1 and ~(2e)-1 is -2(e+1).
      special = (k_d == 4'd0) &&
                ($signed({b_cur, 1'b0}) <= -$signed({6'd0, n_cur}));
      two_e   = {err[7:0], 1'b0};
      if (!err[11]) begin
         merr_d = two_e + {8'd0, special};
      end else begin
         merr_d = special ? (~two_e - 9'd1) : ~two_e;
      end

      // Statistics update.
      b_t = $signed({{2{b_cur[11]}}, b_cur}) + $signed({{2{err[11]}}, err});
      a_t = a_cur + A_W'($unsigned(abs_err));
      n_t = {1'b0, n_cur};
      c_t = c_cur;
      if (n_cur == RESET_N7) begin
         a_t = a_t >> 1;
         b_t = b_t >>> 1;
         n_t = n_t >> 1;
      end
      n_t   = n_t + 8'd1;
      n_pos = $signed({6'd0, n_t});
      n_neg = -n_pos;
      if (b_t <= n_neg) begin
         b_t = b_t + n_pos;
         if (c_t != C_MIN) begin
            c_t = c_t - 8'sd1;
         end
         if (b_t <= n_neg) begin
            b_t = n_neg + 14'sd1;
         end
      end else if (b_t > 14'sd0) begin
         b_t = b_t - n_pos;
         if (c_t != C_MAX) begin
            c_t = c_t + 8'sd1;
         end
         if (b_t > 14'sd0) begin
            b_t = 14'sd0;
         end
      end

      ctx_new = '{a: a_t, b: b_t[11:0], c: c_t, n: n_t[6:0]};
   end

   // Stage-2 output registers and write-back copy for the bypass.
   logic [8:0] merr_q;
   logic [3:0] k_q;
   logic       en_out_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         merr_q   <= '0;
         k_q      <= '0;
         en_out_q <= 1'b0;
         wb_q     <= '0;
      end else begin
         en_out_q <= v1_q;
         merr_q   <= v1_q ? merr_d : 9'd0;
         k_q      <= v1_q ? k_d : 4'd0;
         if (v1_q) begin
            wb_q <= ctx_new;
         end
      end
   end

   assign MErrval = merr_q;
   assign k       = k_q;
   assign en_out  = en_out_q;

endmodule

// File: tb/tb_context_update.sv
// -----------------------------------------------------------------------------
// tb_context_update
//
// Self-checking bench for context_update. A behavioural model holds the
// context statistics as plain integer arrays and processes every accepted
// sample in order, straight from the LOCO-I update rules. Directed samples
// additionally carry hand-derived expected outputs.
// -----------------------------------------------------------------------------
module tb_context_update;

   localparam int CTX_NUM = 365;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [8:0] Q = '0;
   logic       sign = 1'b0;
   logic [8:0] Ix = '0;
   logic [8:0] Px = '0;
   logic [8:0] MErrval;
   logic [3:0] k;
   logic       en_out;
   logic       init_busy;

   always #5 clk = ~clk;

   context_update dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .Q         (Q),
      .sign      (sign),
      .Ix        (Ix),
      .Px        (Px),
      .MErrval   (MErrval),
      .k         (k),
      .en_out    (en_out),
      .init_busy (init_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected output of one sample.
   typedef struct {
      bit v;
      int m;
      int kk;
      bit hc;   // hand-derived constants present
      int cm;
      int ck;
   } exp_t;

   exp_t pend;

   int ma [CTX_NUM];
   int mb [CTX_NUM];
   int mc [CTX_NUM];
   int mn [CTX_NUM];
   bit in_run = 1'b0;

   function automatic void model_init();
      for (int i = 0; i < CTX_NUM; i++) begin
         ma[i] = 4;
         mb[i] = 0;
         mc[i] = 0;
         mn[i] = 1;
      end
   endfunction

   function automatic exp_t model(input bit e, input int q, input bit s,
                                  input int ix, input int px);
      exp_t r;
      int   pxp;
      int   err;
      int   kk;
      int   m;
      r.v  = 1'b0;
      r.m  = 0;
      r.kk = 0;
      r.hc = 1'b0;
      r.cm = 0;
      r.ck = 0;
      if (!e || !in_run || q >= CTX_NUM) return r;

      pxp = s ? px - mc[q] : px + mc[q];
      if (pxp < 0)   pxp = 0;
      if (pxp > 255) pxp = 255;
      err = ix - pxp;
      if (s) err = -err;
      if (err < -128)      err += 256;
      else if (err >= 128) err -= 256;

      kk = 0;
      while (kk < 15 && (mn[q] << kk) < ma[q]) kk++;

      if (kk == 0 && 2 * mb[q] <= -mn[q])
         m = (err >= 0) ? 2 * err + 1 : -2 * (err + 1);
      else
         m = (err >= 0) ? 2 * err : -2 * err - 1;

      mb[q] += err;
      ma[q] += (err < 0) ? -err : err;
      if (mn[q] == 64) begin
         ma[q] = ma[q] / 2;
         mb[q] = (mb[q] < 0) ? -((-mb[q] + 1) / 2) : mb[q] / 2;  // floor(B/2)
         mn[q] = mn[q] / 2;
      end
      mn[q] += 1;
      if (mb[q] <= -mn[q]) begin
         mb[q] += mn[q];
         if (mc[q] > -128) mc[q] -= 1;
         if (mb[q] <= -mn[q]) mb[q] = -mn[q] + 1;
      end else if (mb[q] > 0) begin
         mb[q] -= mn[q];
         if (mc[q] < 127) mc[q] += 1;
         if (mb[q] > 0) mb[q] = 0;
      end

      r.v  = 1'b1;
      r.m  = m;
      r.kk = kk;
      return r;
   endfunction

   // Drive one sample (or bubble), advance one clock, check the output that
   // belongs to the sample driven one call earlier.
   task automatic cycle(input bit e, input int q, input bit s, input int ix,
                        input int px, input bit hc = 1'b0, input int cm = 0,
                        input int ck = 0);
      exp_t nw;
      exp_t prev;
      en   = e;
      Q    = q[8:0];
      sign = s;
      Ix   = ix[8:0];
      Px   = px[8:0];
      nw    = model(e, q, s, ix, px);
      nw.hc = hc;
      nw.cm = cm;
      nw.ck = ck;
      prev  = pend;
      pend  = nw;
      @(posedge clk);
      #1;
      check("en_out", en_out, prev.v);
      if (prev.v) begin
         check("MErrval", MErrval, prev.m);
         check("k", k, prev.kk);
         if (prev.hc) begin
            check("MErrval_directed", MErrval, prev.cm);
            check("k_directed", k, prev.ck);
         end
      end else begin
         check("MErrval_idle", MErrval, 0);
         check("k_idle", k, 0);
      end
      check("init_busy_run", init_busy, 0);
   endtask

   // Called just after reset release: counts INIT cycles while throwing
   // random traffic at the (ignored) inputs.
   task automatic wait_init();
      int cnt;
      bit done;
      cnt    = 0;
      done   = 1'b0;
      pend.v = 1'b0;
      in_run = 1'b0;
      model_init();
      while (!done && cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
         check("en_out_init", en_out, 0);
         if (!init_busy) begin
            done = 1'b1;
         end else begin
            en   = 1'($urandom_range(0, 1));
            Q    = 9'($urandom_range(0, 364));
            Ix   = 9'($urandom_range(0, 255));
            Px   = 9'($urandom_range(0, 255));
            sign = 1'($urandom_range(0, 1));
         end
      end
      check("init_cycles", cnt, 365);
      en     = 1'b0;
      in_run = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int q;
      int r;
      int px;
      int ix;
      pend.v  = 1'b0;
      pend.m  = 0;
      pend.kk = 0;
      pend.hc = 1'b0;
      pend.cm = 0;
      pend.ck = 0;

      // Reset values.
      #12;
      check("rst_en_out", en_out, 0);
      check("rst_MErrval", MErrval, 0);
      check("rst_k", k, 0);
      check("rst_init_busy", init_busy, 1);
      #10;
      reset = 1'b1;
      wait_init();

      // Directed samples from fresh contexts.
      cycle(1, 5, 0, 103, 100, 1, 6, 2);
      cycle(1, 5, 0, 100, 100, 1, 1, 2);    // back-to-back, needs the bypass
      cycle(1, 7, 1, 40, 50, 1, 20, 2);
      cycle(1, 9, 0, 255, 0, 1, 1, 2);      // modulo wrap
      cycle(1, 364, 0, 103, 100, 1, 6, 2);  // last table entry
      cycle(1, 365, 0, 103, 100);           // out of range, dropped
      cycle(1, 511, 1, 10, 200);            // out of range, dropped
      cycle(0, 0, 0, 0, 0);

      // Halving: 64 zero-error samples, then probes of the halved context.
      repeat (64) cycle(1, 11, 0, 128, 128);
      cycle(1, 11, 0, 133, 128, 1, 10, 0);
      cycle(1, 11, 0, 128, 128, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Random traffic over a few hot contexts (frequent repeats and
      // back-to-back hits), the top entries, and out-of-range indices.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 19);
         if (r < 14)      q = $urandom_range(0, 7);
         else if (r < 17) q = $urandom_range(360, 364);
         else             q = $urandom_range(365, 511);
         px = $urandom_range(0, 255);
         if ($urandom_range(0, 1) == 1)
            ix = (px + $urandom_range(0, 8) - 4) & 255;
         else
            ix = $urandom_range(0, 255);
         cycle(($urandom_range(0, 99) < 85), q, 1'($urandom_range(0, 1)), ix, px);
      end

      // Reset in the middle of traffic.
      cycle(1, 5, 0, 90, 100);
      cycle(1, 6, 1, 120, 30);
      check("pre_rst_en_out", en_out, 1);
      reset = 1'b0;
      #1;
      check("midrst_en_out", en_out, 0);
      check("midrst_MErrval", MErrval, 0);
      check("midrst_k", k, 0);
      check("midrst_init_busy", init_busy, 1);
      #20;
      reset = 1'b1;
      wait_init();
      cycle(1, 5, 0, 103, 100, 1, 6, 2);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
